// File: rtl/cfg_host_if.sv
// Host request/ack bus to one-hot configuration register write strobes.
// Decodes the fixed register map, returns read data and counts bad accesses.
module cfg_host_if #(
  parameter int NUM_OF_REG = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic       wr_rd,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] reg_data_0,
  input  logic [7:0] reg_data_1,
  input  logic [7:0] reg_data_2,
  input  logic [7:0] reg_data_3,
  output logic       ack,
  output logic       err,
  output logic [7:0] rdata,
  output logic [7:0] wr_en,
  output logic [7:0] wr_data,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t                  r_state;
  logic                    r_wr;
  logic [7:0]              r_addr;
  logic [NUM_OF_REG-1:0]   w_in_oh;
  logic [NUM_OF_REG-1:0]   w_lat_oh;
  logic                    w_lat_hit;
  logic [7:0]              w_rsel;

  function automatic logic [NUM_OF_REG-1:0] f_dec(
    input logic [7:0] a
  );
    logic [NUM_OF_REG-1:0] oh;
    oh = '0;
    case (a)
      8'h00:   oh[0] = 1'b1;
      8'h02:   oh[1] = 1'b1;
      8'h04:   oh[2] = 1'b1;
      8'h08:   oh[3] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

  assign w_in_oh   = f_dec(addr);
  assign w_lat_oh  = f_dec(r_addr);
  assign w_lat_hit = |w_lat_oh;

  always_comb begin
    w_rsel = 8'h00;
    unique case (1'b1)
      w_lat_oh[0]: w_rsel = reg_data_0;
      w_lat_oh[1]: w_rsel = reg_data_1;
      w_lat_oh[2]: w_rsel = reg_data_2;
      w_lat_oh[3]: w_rsel = reg_data_3;
      default:     w_rsel = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wr    <= 1'b0;
      r_addr  <= 8'h00;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= 8'h00;
      wr_en   <= 8'h00;
      wr_data <= 8'h00;
      err_cnt <= 8'h00;
    end else begin
      ack   <= 1'b0;
      err   <= 1'b0;
      wr_en <= 8'h00;
      case (r_state)
        S_IDLE: begin
          if (sel) begin
            r_wr    <= wr_rd;
            r_addr  <= addr;
            wr_data <= wdata;
            // strobe lands in the ACCESS cycle
            if (wr_rd)
              wr_en <= {{(8-NUM_OF_REG){1'b0}}, w_in_oh};
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          ack <= 1'b1;
          err <= ~w_lat_hit;
          if (!w_lat_hit) begin
            rdata <= 8'h00;
            if (err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
          end else if (!r_wr) begin
            rdata <= w_rsel;
          end
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_state <= sel ? S_RELEASE : S_IDLE;
        end
        S_RELEASE: begin
          if (!sel)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_host_if.sv
// Directed bench for cfg_host_if: transaction-level model compared every
// cycle, plus literal expectations on key transactions.
module tb_cfg_host_if;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       wr_rd;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       ack;
  logic       err;
  logic [7:0] rdata;
  logic [7:0] wr_en;
  logic [7:0] wr_data;
  logic [7:0] err_cnt;
  logic [7:0] regs [4] = '{default: 8'h00};

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  cfg_host_if #(.NUM_OF_REG(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .wr_rd      (wr_rd),
    .addr       (addr),
    .wdata      (wdata),
    .reg_data_0 (regs[0]),
    .reg_data_1 (regs[1]),
    .reg_data_2 (regs[2]),
    .reg_data_3 (regs[3]),
    .ack        (ack),
    .err        (err),
    .rdata      (rdata),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .err_cnt    (err_cnt)
  );

  // register block stand-in
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (wr_en[i]) regs[i] <= wr_data;
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [7:0] a);
    case (a)
      8'h00:   return 0;
      8'h02:   return 1;
      8'h04:   return 2;
      8'h08:   return 3;
      default: return -1;
    endcase
  endfunction

  // transaction-level model: accepted request -> strobe now, ack next
  logic [7:0] m_wr_en, m_wr_data, m_rdata, m_cnt;
  logic       m_ack, m_err;
  logic       p_wr;
  logic [7:0] p_addr;
  bit         pend, ready, after_ack;

  always @(posedge clk) begin
    int k;
    if (rst) begin
      m_wr_en = 0; m_wr_data = 0; m_rdata = 0; m_cnt = 0;
      m_ack = 0; m_err = 0;
      pend = 0; ready = 1; after_ack = 0;
    end else begin
      m_wr_en = 0;
      m_ack   = 0;
      m_err   = 0;
      if (pend) begin
        pend = 0;
        after_ack = 1;
        m_ack = 1;
        k = idx_of(p_addr);
        if (k < 0) begin
          m_err = 1;
          m_rdata = 8'h00;
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end else if (!p_wr) begin
          m_rdata = regs[k];
        end
      end else if (ready) begin
        if (sel) begin
          ready = 0;
          pend = 1;
          p_wr = wr_rd;
          p_addr = addr;
          m_wr_data = wdata;
          k = idx_of(addr);
          if (wr_rd && k >= 0) m_wr_en = 8'(1 << k);
        end
      end else if (after_ack && !sel) begin
        ready = 1;
        after_ack = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ack", {7'd0, ack}, {7'd0, m_ack});
      chk("err", {7'd0, err}, {7'd0, m_err});
      chk("rdata", rdata, m_rdata);
      chk("wr_en", wr_en, m_wr_en);
      chk("wr_data", wr_data, m_wr_data);
      chk("err_cnt", err_cnt, m_cnt);
    end
  end

  task automatic do_txn(input logic w, input logic [7:0] a,
                        input logic [7:0] d, output int lat,
                        output logic [7:0] wen1, output logic e);
    @(negedge clk);
    sel = 1'b1; wr_rd = w; addr = a; wdata = d;
    lat = 0;
    wen1 = 8'h00;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) wen1 = wr_en;
    end while (!ack && lat < 8);
    chk("ack_timeout", {7'd0, ack}, 8'h01);
    e = err;
    sel = 1'b0;
  endtask

  initial begin
    int lat;
    logic [7:0] wen1;
    logic e;
    int na, nw;
    logic [7:0] ta [5] = '{8'h04, 8'h00, 8'h02, 8'h08, 8'h06};
    logic [7:0] tw [5] = '{8'h04, 8'h01, 8'h02, 8'h08, 8'h00};
    logic [7:0] td [5] = '{8'hA5, 8'h11, 8'h22, 8'h3C, 8'hEE};

    rst = 1'b1; sel = 1'b1; wr_rd = 1'b1; addr = 8'h04; wdata = 8'h77;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_ack", {7'd0, ack}, 8'h00);
    chk("rst_wr_en", wr_en, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_err_cnt", err_cnt, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_wen", wr_en, 8'h04);
    chk("post_rst_wdata", wr_data, 8'h77);
    @(negedge clk);
    chk("post_rst_ack", {7'd0, ack}, 8'h01);
    sel = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_txn(1'b1, ta[i], td[i], lat, wen1, e);
      chk("wr_latency", 8'(lat), 8'd2);
      chk("wr_onehot", wen1, tw[i]);
      chk("wr_err", {7'd0, e}, (i == 4) ? 8'h01 : 8'h00);
    end
    chk("err_cnt_one", err_cnt, 8'h01);

    do_txn(1'b0, 8'h08, 8'h00, lat, wen1, e);
    chk("rd3_data", rdata, 8'h3C);
    chk("rd3_wen", wen1, 8'h00);
    do_txn(1'b0, 8'h04, 8'h00, lat, wen1, e);
    chk("rd2_data", rdata, 8'hA5);

    for (int i = 0; i < 300; i++) begin
      do_txn(i[0], 8'(8'h10 + i[3:0]), 8'(i), lat, wen1, e);
    end
    chk("err_cnt_sat", err_cnt, 8'hFF);

    @(negedge clk);
    sel = 1'b1; wr_rd = 1'b1; addr = 8'h02; wdata = 8'h5A;
    na = 0; nw = 0;
    repeat (12) begin
      @(negedge clk);
      if (ack) na++;
      if (wr_en != 8'h00) nw++;
    end
    chk("held_acks", 8'(na), 8'd1);
    chk("held_wens", 8'(nw), 8'd1);
    sel = 1'b0;
    do_txn(1'b0, 8'h02, 8'h00, lat, wen1, e);
    chk("held_next_lat", 8'(lat), 8'd2);
    chk("held_next_rd", rdata, 8'h5A);

    @(negedge clk);
    sel = 1'b1; wr_rd = 1'b1; addr = 8'h00; wdata = 8'h99;
    @(negedge clk);
    chk("mid_wen", wr_en, 8'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; sel = 1'b0;
    na = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack) na++;
    end
    chk("mid_no_ack", 8'(na), 8'd0);
    chk("mid_err_cnt", err_cnt, 8'h00);
    do_txn(1'b0, 8'h00, 8'h00, lat, wen1, e);
    chk("mid_rd0", rdata, 8'h99);
    chk("mid_rd_lat", 8'(lat), 8'd2);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
